// File: rtl/extram_arbiter.sv
// Arbiter for the shared 512 KiB x 8 async SRAM: VGA scan-out reads win, Wishbone fills idle cycles.
// Optional sticky VGA overrun flag O_vga_late is built when RAMARB_OVERRUN_EN is defined.
module extram_arbiter #(
  parameter int unsigned ADR_WIDTH = 19
) (
  input  logic                 I_clk,
  input  logic                 I_reset_n,
  input  logic                 I_vga_req,
  input  logic [ADR_WIDTH-1:0] I_vga_adr,
  output logic [7:0]           O_vga_dat,
  input  logic                 I_wb_stb,
  input  logic                 I_wb_we,
  input  logic [ADR_WIDTH-1:0] I_wb_adr,
  input  logic [7:0]           I_wb_dat,
  output logic                 O_wb_ack,
  output logic [7:0]           O_wb_dat,
  output logic [ADR_WIDTH-1:0] O_sram_adr,
  output logic [7:0]           O_sram_dat,
  output logic                 O_sram_dat_oe,
  input  logic [7:0]           I_sram_dat,
  output logic                 O_sram_ce_n,
  output logic                 O_sram_oe_n,
  output logic                 O_sram_we_n
`ifdef RAMARB_OVERRUN_EN
  ,
  output logic                 O_vga_late
`endif
);

  typedef enum logic [2:0] {IDLE, VRD, WRD, WR1, WR2} state_t;

  state_t                 state;
  logic                   slot_valid;
  logic [ADR_WIDTH-1:0]   slot_adr;

  logic                   decide_c;
  logic                   ack_due_c;
  logic                   vga_go_c;
  logic                   wb_go_c;
  logic [ADR_WIDTH-1:0]   vga_adr_c;

  // Issue decision; an ack already owed blocks re-issuing the same Wishbone cycle.
  assign decide_c  = (state != WR1);
  assign ack_due_c = (state == WRD) || (state == WR2);
  assign vga_go_c  = decide_c && (I_vga_req || slot_valid);
  assign vga_adr_c = I_vga_req ? I_vga_adr : slot_adr;
  assign wb_go_c   = decide_c && !vga_go_c && I_wb_stb && !O_wb_ack && !ack_due_c;

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state         <= IDLE;
      slot_valid    <= 1'b0;
      slot_adr      <= '0;
      O_sram_adr    <= '0;
      O_sram_dat    <= '0;
      O_sram_dat_oe <= 1'b0;
      O_sram_ce_n   <= 1'b1;
      O_sram_oe_n   <= 1'b1;
      O_sram_we_n   <= 1'b1;
      O_vga_dat     <= '0;
      O_wb_dat      <= '0;
      O_wb_ack      <= 1'b0;
`ifdef RAMARB_OVERRUN_EN
      O_vga_late    <= 1'b0;
`endif
    end else begin
      O_wb_ack <= ack_due_c;
      if (state == VRD) O_vga_dat <= I_sram_dat;
      if (state == WRD) O_wb_dat  <= I_sram_dat;

`ifdef RAMARB_OVERRUN_EN
      if (I_vga_req && slot_valid) O_vga_late <= 1'b1;
`endif

      // VGA requests that cannot issue this edge park in the slot (newest wins).
      if (vga_go_c) begin
        slot_valid <= 1'b0;
      end else if (I_vga_req) begin
        slot_valid <= 1'b1;
        slot_adr   <= I_vga_adr;
      end

      if (state == WR1) begin
        state         <= WR2;
        O_sram_ce_n   <= 1'b0;
        O_sram_oe_n   <= 1'b1;
        O_sram_we_n   <= 1'b1;
      end else if (vga_go_c) begin
        state         <= VRD;
        O_sram_adr    <= vga_adr_c;
        O_sram_dat_oe <= 1'b0;
        O_sram_ce_n   <= 1'b0;
        O_sram_oe_n   <= 1'b0;
        O_sram_we_n   <= 1'b1;
      end else if (wb_go_c && !I_wb_we) begin
        state         <= WRD;
        O_sram_adr    <= I_wb_adr;
        O_sram_dat_oe <= 1'b0;
        O_sram_ce_n   <= 1'b0;
        O_sram_oe_n   <= 1'b0;
        O_sram_we_n   <= 1'b1;
      end else if (wb_go_c) begin
        state         <= WR1;
        O_sram_adr    <= I_wb_adr;
        O_sram_dat    <= I_wb_dat;
        O_sram_dat_oe <= 1'b1;
        O_sram_ce_n   <= 1'b0;
        O_sram_oe_n   <= 1'b1;
        O_sram_we_n   <= 1'b0;
      end else begin
        state         <= IDLE;
        O_sram_dat_oe <= 1'b0;
        O_sram_ce_n   <= 1'b1;
        O_sram_oe_n   <= 1'b1;
        O_sram_we_n   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_extram_arbiter.sv
// Bench for extram_arbiter: SRAM model, Wishbone/VGA drivers, per-cycle bus and latency checks.
module tb_extram_arbiter;

  logic        I_clk = 1'b0;
  logic        I_reset_n;
  logic        I_vga_req;
  logic [18:0] I_vga_adr;
  logic [7:0]  O_vga_dat;
  logic        I_wb_stb;
  logic        I_wb_we;
  logic [18:0] I_wb_adr;
  logic [7:0]  I_wb_dat;
  logic        O_wb_ack;
  logic [7:0]  O_wb_dat;
  logic [18:0] O_sram_adr;
  logic [7:0]  O_sram_dat;
  logic        O_sram_dat_oe;
  logic [7:0]  I_sram_dat;
  logic        O_sram_ce_n;
  logic        O_sram_oe_n;
  logic        O_sram_we_n;
`ifdef RAMARB_OVERRUN_EN
  logic        O_vga_late;
`endif

  extram_arbiter #(.ADR_WIDTH(19)) dut (
    .I_clk(I_clk), .I_reset_n(I_reset_n),
    .I_vga_req(I_vga_req), .I_vga_adr(I_vga_adr), .O_vga_dat(O_vga_dat),
    .I_wb_stb(I_wb_stb), .I_wb_we(I_wb_we), .I_wb_adr(I_wb_adr), .I_wb_dat(I_wb_dat),
    .O_wb_ack(O_wb_ack), .O_wb_dat(O_wb_dat),
    .O_sram_adr(O_sram_adr), .O_sram_dat(O_sram_dat), .O_sram_dat_oe(O_sram_dat_oe),
    .I_sram_dat(I_sram_dat),
    .O_sram_ce_n(O_sram_ce_n), .O_sram_oe_n(O_sram_oe_n), .O_sram_we_n(O_sram_we_n)
`ifdef RAMARB_OVERRUN_EN
    , .O_vga_late(O_vga_late)
`endif
  );

  always #5 I_clk = ~I_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  // VGA region (>= 0x20000) is never written, so its contents are a fixed function of address.
  function automatic logic [7:0] golden(input logic [18:0] a);
    if (a == 19'h20000) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h3C;
  endfunction

  logic [7:0] sram [0:524287];
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] ref_rd(input logic [18:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return golden(a);
  endfunction

  assign I_sram_dat = (!O_sram_ce_n && !O_sram_oe_n) ? sram[O_sram_adr] : 8'h00;
  always @(posedge I_clk)
    if (I_reset_n && !O_sram_ce_n && !O_sram_we_n && O_sram_dat_oe)
      sram[O_sram_adr] <= O_sram_dat;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(act === exp, name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge I_clk);
    #1;
  endtask

  bit wb_active = 1'b0;
  bit vga_mon_off = 1'b0;

  // One Wishbone transaction; scoreboard updated on write ack, read data compared at ack.
  task automatic wb_txn(input bit we, input logic [18:0] adr, input logic [7:0] dat,
                        output logic [7:0] rdat, output int lat);
    int s;
    bit got;
    wb_active = 1'b1;
    I_wb_stb = 1'b1; I_wb_we = we; I_wb_adr = adr; I_wb_dat = dat;
    s = cyc; got = 1'b0; lat = 0; rdat = 8'h00;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge I_clk);
      if (O_wb_ack) begin
        got = 1'b1;
        lat = cyc - s;
        rdat = O_wb_dat;
      end
    end
    if (!got) chk(1'b0, "wb_ack_timeout", 32'(adr), 32'(we));
    else begin
      chk(lat >= (we ? 3 : 2), "wb_min_latency", 32'(lat), we ? 32'd3 : 32'd2);
      if (we) ref_mem[int'(adr)] = dat;
      else chk_eq("wb_rdata", 32'(rdat), 32'(ref_rd(adr)));
    end
    @(posedge I_clk); #1;
    I_wb_stb = 1'b0;
    wb_active = 1'b0;
  endtask

  typedef struct {
    int          t;
    int          vrd;
    logic [18:0] adr;
  } vexp_t;
  vexp_t vq[$];

  bit          prev_wr1;
  bit          prev_ack;
  logic [18:0] prev_adr;
  logic [7:0]  prev_dat;

  // Per-cycle bus protocol, ack shape and VGA latency/data contract.
  always @(negedge I_clk) begin
    if (!I_reset_n) begin
      prev_wr1 = 1'b0;
      prev_ack = 1'b0;
      vq.delete();
    end else begin
      if (!O_sram_oe_n)
        chk(!O_sram_ce_n && O_sram_we_n && !O_sram_dat_oe, "read_strobes",
            32'({O_sram_ce_n, O_sram_we_n, O_sram_dat_oe}), 32'b010);
      if (!O_sram_we_n)
        chk(!O_sram_ce_n && O_sram_oe_n && O_sram_dat_oe, "wr1_strobes",
            32'({O_sram_ce_n, O_sram_oe_n, O_sram_dat_oe}), 32'b011);
      if (prev_wr1)
        chk(!O_sram_ce_n && O_sram_we_n && O_sram_dat_oe && O_sram_adr == prev_adr &&
            O_sram_dat == prev_dat, "wr2_hold",
            32'({O_sram_ce_n, O_sram_we_n, O_sram_dat_oe, O_sram_dat}),
            32'({1'b0, 1'b1, 1'b1, prev_dat}));
      if (O_sram_ce_n)
        chk(O_sram_oe_n && O_sram_we_n && !O_sram_dat_oe, "idle_strobes",
            32'({O_sram_oe_n, O_sram_we_n, O_sram_dat_oe}), 32'b110);
      if (O_wb_ack)
        chk(wb_active && !prev_ack, "ack_pulse", 32'({wb_active, prev_ack}), 32'b10);

      foreach (vq[i]) begin
        if (cyc == vq[i].vrd)
          chk_eq("vga_issue", 32'({O_sram_oe_n, O_sram_adr}), 32'({1'b0, vq[i].adr}));
        if (cyc == vq[i].vrd + 1 || cyc == vq[i].t + 3)
          chk_eq("vga_dat", 32'(O_vga_dat), 32'(golden(vq[i].adr)));
      end
      while (vq.size() > 0 && vq[0].t + 3 <= cyc) void'(vq.pop_front());

      if (I_vga_req && !vga_mon_off)
        vq.push_back('{t: cyc, adr: I_vga_adr,
                       vrd: (!O_sram_we_n && !O_sram_ce_n) ? cyc + 2 : cyc + 1});

      prev_wr1 = !O_sram_we_n && !O_sram_ce_n;
      prev_adr = O_sram_adr;
      prev_dat = O_sram_dat;
      prev_ack = O_wb_ack;
    end
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  logic [7:0] rd;
  int         lat;
  bit         vga_done;
  int         t;

  initial begin
    for (int i = 0; i < 524288; i++) sram[i] = golden(19'(i));
    I_reset_n = 1'b0;
    I_vga_req = 1'b0; I_vga_adr = '0;
    I_wb_stb = 1'b0; I_wb_we = 1'b0; I_wb_adr = '0; I_wb_dat = '0;
    step(3);

    chk_eq("rst_sram_adr", 32'(O_sram_adr), 32'h0);
    chk_eq("rst_sram_dat", 32'({O_sram_dat, O_sram_dat_oe}), 32'h0);
    chk_eq("rst_strobes", 32'({O_sram_ce_n, O_sram_oe_n, O_sram_we_n}), 32'b111);
    chk_eq("rst_outs", 32'({O_vga_dat, O_wb_dat, O_wb_ack}), 32'h0);
`ifdef RAMARB_OVERRUN_EN
    chk_eq("rst_late", 32'(O_vga_late), 32'h0);
`endif

    I_reset_n = 1'b1;
    step(2);
    chk_eq("idle_strobes_after_release", 32'({O_sram_ce_n, O_sram_oe_n, O_sram_we_n, O_sram_dat_oe}), 32'b1110);
    chk_eq("idle_ack_vga", 32'({O_wb_ack, O_vga_dat}), 32'h0);

    // VGA only.
    I_vga_req = 1'b1; I_vga_adr = 19'h20000;
    step(1);
    I_vga_req = 1'b0;
    @(negedge I_clk);
    chk_eq("vga_only_adr", 32'(O_sram_adr), 32'h20000);
    chk_eq("vga_only_oe_n", 32'(O_sram_oe_n), 32'h0);
    @(negedge I_clk);
    chk_eq("vga_only_dat", 32'(O_vga_dat), 32'h5A);
    step(1);

    // Write then read back.
    wb_txn(1'b1, 19'h01234, 8'hC3, rd, lat);
    chk_eq("wr_latency", 32'(lat), 32'd3);
    wb_txn(1'b0, 19'h01234, 8'h00, rd, lat);
    chk_eq("rd_latency", 32'(lat), 32'd2);
    chk_eq("rd_back_dat", 32'(rd), 32'hC3);

    // VGA arrives during WR1.
    fork
      begin
        wb_txn(1'b1, 19'h00777, 8'h96, rd, lat);
        chk_eq("coll_wr_latency", 32'(lat), 32'd3);
      end
      begin
        step(1);
        I_vga_req = 1'b1; I_vga_adr = 19'h45678;
        @(negedge I_clk);
        chk_eq("coll_in_wr1", 32'(O_sram_we_n), 32'h0);
        step(1);
        I_vga_req = 1'b0;
        @(negedge I_clk);
        chk_eq("coll_wr2", 32'({O_sram_ce_n, O_sram_we_n}), 32'b01);
        @(negedge I_clk);
        chk_eq("coll_vrd", 32'({O_sram_oe_n, O_sram_adr}), 32'({1'b0, 19'h45678}));
        @(negedge I_clk);
        chk_eq("coll_vga_dat", 32'(O_vga_dat), 32'(golden(19'h45678)));
      end
    join
    step(1);
    wb_txn(1'b0, 19'h00777, 8'h00, rd, lat);
    chk_eq("coll_rd_back", 32'(rd), 32'h96);

    // 640 VGA requests every 2 cycles plus a Wishbone stream.
    vga_done = 1'b0;
    fork
      begin
        repeat (640) begin
          I_vga_req = 1'b1;
          I_vga_adr = 19'(32'h20000 + ($urandom % 32'h60000));
          step(1);
          I_vga_req = 1'b0;
          step(1);
        end
        vga_done = 1'b1;
      end
      begin
        while (!vga_done) begin
          int gap;
          wb_txn($urandom_range(0, 3) == 0, 19'($urandom_range(0, 32'h1FFFF)), 8'($urandom), rd, lat);
          gap = $urandom_range(0, 1);
          if (gap > 0) step(gap);
        end
      end
    join
    step(4);

    // Randomly spaced VGA with mixed Wishbone traffic on a small hot address set.
    vga_done = 1'b0;
    fork
      begin
        repeat (200) begin
          I_vga_req = 1'b1;
          I_vga_adr = 19'(32'h20000 + ($urandom % 32'h60000));
          step(1);
          I_vga_req = 1'b0;
          step($urandom_range(1, 4));
        end
        vga_done = 1'b1;
      end
      begin
        while (!vga_done) begin
          int gap;
          wb_txn($urandom_range(0, 1) == 1, 19'($urandom_range(0, 15)), 8'($urandom), rd, lat);
          gap = $urandom_range(0, 2);
          if (gap > 0) step(gap);
        end
      end
    join
    step(4);

`ifdef RAMARB_OVERRUN_EN
    chk_eq("late_before_overrun", 32'(O_vga_late), 32'h0);
    vga_mon_off = 1'b1;
    fork
      wb_txn(1'b1, 19'h00042, 8'h11, rd, lat);
      begin
        step(1);
        I_vga_req = 1'b1; I_vga_adr = 19'h30000;
        step(1);
        I_vga_adr = 19'h51111;
        step(1);
        I_vga_req = 1'b0;
      end
    join
    step(3);
    chk_eq("late_set", 32'(O_vga_late), 32'h1);
    chk_eq("overrun_newer_wins", 32'(O_vga_dat), 32'(golden(19'h51111)));
    step(10);
    chk_eq("late_sticky", 32'(O_vga_late), 32'h1);
    vga_mon_off = 1'b0;
`endif

    // Reset in the middle of a write.
    wb_active = 1'b1;
    I_wb_stb = 1'b1; I_wb_we = 1'b1; I_wb_adr = 19'h00100; I_wb_dat = 8'hEE;
    step(1);
    chk_eq("abort_in_wr1", 32'(O_sram_we_n), 32'h0);
    #2;
    I_reset_n = 1'b0;
    #1;
    chk_eq("abort_strobes", 32'({O_sram_ce_n, O_sram_oe_n, O_sram_we_n, O_sram_dat_oe}), 32'b1110);
    chk_eq("abort_ack", 32'(O_wb_ack), 32'h0);
`ifdef RAMARB_OVERRUN_EN
    chk_eq("late_cleared", 32'(O_vga_late), 32'h0);
`endif
    I_wb_stb = 1'b0;
    wb_active = 1'b0;
    step(2);
    I_reset_n = 1'b1;
    repeat (6) begin
      @(negedge I_clk);
      chk_eq("no_ack_after_abort", 32'(O_wb_ack), 32'h0);
    end
    step(1);
    wb_txn(1'b0, 19'h00100, 8'h00, rd, lat);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/extram_arbiter.md
# extram_arbiter

Single-port arbiter for the 512 KiB × 8 external asynchronous SRAM, shared between the VGA scan-out fetch port and the CPU's 8-bit Wishbone data port. VGA reads always win and complete with bounded, fixed-maximum latency. CPU reads and writes fill the remaining bus cycles. All SRAM control outputs are registered and glitch-free.

## Interface
- ADR_WIDTH, 19, SRAM/requester address width.

- I_clk  in  1  system clock, shared by VGA and Wishbone sides.
- I_reset_n  in  1  asynchronous, active-low reset.
- I_vga_req  in  1  one-cycle VGA read request; at most one per 2 cycles.
- I_vga_adr  in  ADR_WIDTH  VGA read address, valid with I_vga_req.
- O_vga_dat  out  8  last VGA read data, held until the next VGA capture.
- I_wb_stb  in  1  Wishbone strobe; held until O_wb_ack.
- I_wb_we  in  1  1 = write, 0 = read.
- I_wb_adr  in  ADR_WIDTH  Wishbone byte address.
- I_wb_dat  in  8  Wishbone write data.
- O_wb_ack  out  1  one-cycle acknowledge.
- O_wb_dat  out  8  Wishbone read data, valid while O_wb_ack = 1.
- O_sram_adr  out  ADR_WIDTH  SRAM address.
- O_sram_dat  out  8  SRAM write data.
- O_sram_dat_oe  out  1  tristate enable for O_sram_dat.
- I_sram_dat  in  8  SRAM read data.
- O_sram_ce_n, O_sram_oe_n, O_sram_we_n  out  1 each  active-low SRAM strobes.
- O_vga_late  out  1  sticky VGA overrun flag; present only with RAMARB_OVERRUN_EN.

## Operation
- Reset values:
  - O_sram_adr = 0, O_sram_dat = 0, O_sram_dat_oe = 0.
  - O_sram_ce_n = O_sram_oe_n = O_sram_we_n = 1.
  - O_vga_dat = 0, O_wb_dat = 0, O_wb_ack = 0, O_vga_late = 0.
  - State = IDLE, VGA pending slot empty.
- VGA pending slot:
  - On I_vga_req = 1, the slot captures I_vga_adr.
  - The slot clears when its access is issued.
- States:
  - IDLE: bus idle, all strobes high.
  - VRD: VGA read, 1 cycle.
  - WRD: Wishbone read, 1 cycle.
  - WR1: write, WE_n low.
  - WR2: write recovery, WE_n high, address and data held.
- Decision at every edge where the state is IDLE, VRD, WRD or WR2:
  - VGA request, or slot pending → VRD.
  - Else I_wb_stb = 1, O_wb_ack = 0, I_wb_we = 0 → WRD.
  - Else the same with I_wb_we = 1 → WR1.
  - Else → IDLE.
  - From WR1 the only transition is to WR2.
- VRD / WRD outputs: ce_n = 0, oe_n = 0, we_n = 1, dat_oe = 0. I_sram_dat is sampled at the closing edge into O_vga_dat or O_wb_dat.
- WR1 outputs: ce_n = 0, oe_n = 1, we_n = 0, dat_oe = 1, O_sram_dat = I_wb_dat.
- WR2 outputs: ce_n = 0, we_n = 1. O_sram_adr, O_sram_dat and dat_oe are unchanged.
- A Wishbone transaction is captured at issue time; later changes on I_wb_* are ignored until ack.
- O_wb_ack pulses for the cycle after WRD or WR2. The arbiter does not start a new Wishbone access in a cycle where O_wb_ack = 1.
- A VGA request arriving in WR1 waits in the slot. It issues right after WR2 and preempts any waiting Wishbone access.
- Asynchronous reset mid-access: strobes return high at once, the slot and any pending ack are discarded, and no ack is emitted.

## Timing
- VGA request sampled at the edge closing cycle T:
  - Normal case: VRD in T+1, O_vga_dat updated and valid from T+2.
  - If T+1 is WR2: VRD in T+2, O_vga_dat valid from T+3.
- Contract: O_vga_dat holds the data for a request at T throughout cycle T+3. Requesters sample at the edge closing T+3.
- Wishbone read: O_wb_ack at the earliest 2 cycles after I_wb_stb is first sampled.
- Wishbone write: O_wb_ack at the earliest 3 cycles after I_wb_stb is first sampled.
- Worst-case Wishbone wait is unbounded only under back-to-back VGA load. With 2-cycle VGA spacing, every other cycle is free.

## Configuration
- RAMARB_OVERRUN_EN defined:
  - O_vga_late is added.
  - It sets if I_vga_req = 1 while the slot is still pending (spacing violation). The slot is overwritten by the newer request.
  - It clears only on reset.
- RAMARB_OVERRUN_EN undefined:
  - No port, no logic.
  - The newer request silently overwrites the pending slot.

## Test plan
- Reset release, idle: all strobes 1, dat_oe 0, O_wb_ack 0, O_vga_dat 0.
- VGA only: I_vga_req at T with adr 0x20000, SRAM model returns 0x5A → O_sram_adr = 0x20000 and oe_n = 0 in T+1; O_vga_dat = 0x5A at T+2.
- Write then read: Wishbone write 0x1234 ← 0xC3, then read 0x1234 → WR1/WR2 observed; acks 1 cycle each; read O_wb_dat = 0xC3.
- VGA collides with write: I_vga_req in WR1 cycle → VRD immediately after WR2; O_vga_dat correct by T+3; Wishbone ack unaffected.
- VGA every 2 cycles for 640 requests plus a continuous Wishbone read stream → every VGA datum correct within T+3; Wishbone reads all acked with correct data.
- With RAMARB_OVERRUN_EN: two I_vga_req one cycle apart while the slot is pending → O_vga_late = 1 and stays 1 until I_reset_n = 0.
